// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern link.
// Used by the transmitter and the sequence-detector blocks.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 4;

    localparam logic [3:0] PAT_1001 = 4'b1001;
    localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control/status bundle between a pattern-transmitter driver
// and the seq_pattern_tx block.
interface seq_pattern_tx_if
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [CNT_W-1:0] gap_len;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames_sent;

    modport master (
        output start, abort, pattern, repeat_cnt, gap_len,
        input  dout, dout_valid, busy, done, frames_sent
    );

    modport slave (
        input  start, abort, pattern, repeat_cnt, gap_len,
        output dout, dout_valid, busy, done, frames_sent
    );

endinterface

// File: rtl/piso_shift.sv
// Parallel-load, shift-left register with serial MSB output.
// Load has priority over shift.
module piso_shift #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Moore serial pattern transmitter: sends a captured pattern MSB-first
// for repeat_cnt frames with optional idle gaps, all outputs registered.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic           clk,
    input logic           reset,
    seq_pattern_tx_if.slave bus
);

    localparam int BW = $clog2(PAT_W);

    state_t state;
    state_t state_nx;

    logic [PAT_W-1:0] pat_r;
    logic [PAT_W-1:0] load_data;
    logic [CNT_W-1:0] rep_r;
    logic [CNT_W-1:0] gap_r;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] fr_cnt;
    logic [CNT_W-1:0] frames_sent;
    logic [BW-1:0]    bit_cnt;

    logic accept;
    logic kill;
    logic last_bit;
    logic more;
    logic load;
    logic shift;
    logic msb;
    logic frame_end;
    logic dout_r;
    logic valid_r;
    logic busy_r;
    logic done_r;

    // busy_r is still high during the visible done cycle, so a start
    // there is ignored and only taken one cycle later
    assign accept    = (state == IDLE) && !busy_r && bus.start;
    assign kill      = (state != IDLE) && bus.abort;
    assign last_bit  = (state == SEND) && (bit_cnt == '0);
    assign more      = ({1'b0, fr_cnt} + (CNT_W+1)'(1)) < {1'b0, rep_r};
    assign load_data = (state == IDLE) ? bus.pattern : pat_r;

    piso_shift #(
        .W(PAT_W)
    ) u_piso (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .shift(shift),
        .din  (load_data),
        .msb  (msb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    load     = 1'b1;
                    state_nx = (bus.repeat_cnt != '0) ? SEND : DONE;
                end
            end
            SEND: begin
                if (bit_cnt != '0) begin
                    shift = 1'b1;
                end else if (!more) begin
                    state_nx = DONE;
                end else if (gap_r != '0) begin
                    state_nx = GAP;
                end else begin
                    load = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == CNT_W'(1)) begin
                    load     = 1'b1;
                    state_nx = SEND;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (kill) begin
            state_nx = IDLE;
            load     = 1'b0;
            shift    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_r   <= '0;
            rep_r   <= '0;
            gap_r   <= '0;
            fr_cnt  <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) begin
                pat_r  <= bus.pattern;
                rep_r  <= bus.repeat_cnt;
                gap_r  <= bus.gap_len;
                fr_cnt <= '0;
            end else if (last_bit && !kill) begin
                fr_cnt <= fr_cnt + CNT_W'(1);
            end
            if (load) begin
                bit_cnt <= BW'(PAT_W - 1);
            end else if (shift) begin
                bit_cnt <= bit_cnt - BW'(1);
            end
            if (state == SEND && state_nx == GAP) begin
                gap_cnt <= gap_r;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - CNT_W'(1);
            end
        end
    end

    // Outputs trail the state by one edge; frames_sent trails the last bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_r      <= 1'b0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            frame_end   <= 1'b0;
            frames_sent <= '0;
        end else begin
            dout_r    <= (state == SEND) && msb && !kill;
            valid_r   <= (state == SEND) && !kill;
            busy_r    <= (state != IDLE) && !kill;
            done_r    <= (state == DONE) && !kill;
            frame_end <= last_bit && !kill;
            if (accept) begin
                frames_sent <= '0;
            end else if (frame_end && !kill && frames_sent != '1 &&
                         frames_sent < rep_r) begin
                frames_sent <= frames_sent + CNT_W'(1);
            end
        end
    end

    assign bus.dout        = dout_r;
    assign bus.dout_valid  = valid_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.frames_sent = frames_sent;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed frames plus random traffic
// compared cycle by cycle with a queue-based frame-schedule model.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    localparam int PW = 4;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    seq_pattern_tx_if #(.PAT_W(PW), .CNT_W(CW)) bus ();

    seq_pattern_tx #(
        .PAT_W(PW),
        .CNT_W(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic          dout;
        logic          valid;
        logic          busy;
        logic          done;
        logic [CW-1:0] fs;
    } obs_t;

    int   total    = 0;
    int   bad      = 0;
    bit   finished = 1'b0;
    obs_t cur      = '0;
    obs_t q[$];

    int          busy_tot = 0;
    int          done_tot = 0;
    int          bits_tot = 0;
    int          det_tot  = 0;
    logic [31:0] stream   = '0;

    int b0, d0, n0, e0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.busy) busy_tot <= busy_tot + 1;
            if (bus.done) done_tot <= done_tot + 1;
            if (bus.dout_valid) begin
                bits_tot <= bits_tot + 1;
                stream   <= {stream[30:0], bus.dout};
                if ({stream[2:0], bus.dout} == 4'b1001)
                    det_tot <= det_tot + 1;
            end
        end
    end

    function automatic obs_t dut_obs();
        obs_t o;
        o.dout  = bus.dout;
        o.valid = bus.dout_valid;
        o.busy  = bus.busy;
        o.done  = bus.done;
        o.fs    = bus.frames_sent;
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    // Expected output for every cycle of one transfer, in order
    task automatic build(input logic [PW-1:0] p, input int n, input int g);
        obs_t e;
        for (int k = 1; k <= n; k++) begin
            for (int b = PW - 1; b >= 0; b--) begin
                e = '0;
                e.dout  = p[b];
                e.valid = 1'b1;
                e.busy  = 1'b1;
                e.fs    = CW'(k - 1);
                q.push_back(e);
            end
            if (k < n) begin
                for (int j = 0; j < g; j++) begin
                    e = '0;
                    e.busy = 1'b1;
                    e.fs   = CW'(k);
                    q.push_back(e);
                end
            end
        end
        e = '0;
        e.busy = 1'b1;
        e.done = 1'b1;
        e.fs   = CW'(n);
        q.push_back(e);
    endtask

    task automatic go(input logic [PW-1:0] p, input int n, input int g);
        cyc();
        b0 = busy_tot;
        d0 = done_tot;
        n0 = bits_tot;
        e0 = det_tot;
        bus.pattern    = p;
        bus.repeat_cnt = CW'(n);
        bus.gap_len    = CW'(g);
        bus.start      = 1'b1;
        cyc();
        bus.start   = 1'b0;
        bus.pattern = ~p;
    endtask

    task automatic wait_done(input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (done_tot != d0) begin
                got = 1;
                break;
            end
            bus.start = (i == 2);
        end
        bus.start = 1'b0;
        chk("xfer_timeout", got, 1);
        repeat (3) cyc();
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pattern    = '0;
        bus.repeat_cnt = '0;
        bus.gap_len    = '0;
        fork
            begin : model
                obs_t          nx;
                bit            idle_ok;
                logic [CW-1:0] hold;
                while (!finished) begin
                    @(posedge clk or posedge reset);
                    if (reset) begin
                        q.delete();
                        cur = '0;
                    end else begin
                        idle_ok = (q.size() == 0) && !cur.busy;
                        hold    = cur.fs;
                        nx      = '0;
                        nx.fs   = hold;
                        if (q.size() > 0) begin
                            if (bus.abort) q.delete();
                            else nx = q.pop_front();
                        end
                        if (idle_ok && bus.start) begin
                            nx.fs = '0;
                            build(bus.pattern, int'(bus.repeat_cnt),
                                  int'(bus.gap_len));
                        end
                        cur = nx;
                    end
                end
            end
            begin : compare
                obs_t a;
                while (!finished) begin
                    @(negedge clk);
                    if (!reset && !finished) begin
                        a = dut_obs();
                        total++;
                        if (a !== cur) begin
                            bad++;
                            $display("FAIL cycle t=%0t got %h want %h",
                                     $time, a, cur);
                        end
                    end
                end
            end
            begin : stim
                int got;
                repeat (3) cyc();
                chk("rst_dout", int'(bus.dout), 0);
                chk("rst_valid", int'(bus.dout_valid), 0);
                chk("rst_busy", int'(bus.busy), 0);
                chk("rst_done", int'(bus.done), 0);
                chk("rst_fs", int'(bus.frames_sent), 0);
                reset = 1'b0;
                repeat (2) cyc();

                go(PAT_1001, 1, 0);
                wait_done(30);
                chk("single_bits", int'(stream[3:0]), int'(PAT_1001));
                chk("single_nbits", bits_tot - n0, 4);
                chk("single_busy", busy_tot - b0, 5);
                chk("single_done", done_tot - d0, 1);
                chk("single_fs", int'(bus.frames_sent), 1);

                go(PAT_1001, 2, 0);
                wait_done(30);
                chk("b2b_bits", int'(stream[7:0]), 8'b1001_1001);
                chk("b2b_busy", busy_tot - b0, 9);
                chk("b2b_detect", det_tot - e0, 2);

                go(PAT_1011, 3, 2);
                wait_done(40);
                chk("gap_bits", int'(stream[11:0]), 12'b1011_1011_1011);
                chk("gap_busy", busy_tot - b0, 17);
                chk("gap_fs", int'(bus.frames_sent), 3);

                go(PAT_1011, 0, 1);
                wait_done(10);
                chk("zero_busy", busy_tot - b0, 1);
                chk("zero_done", done_tot - d0, 1);
                chk("zero_nbits", bits_tot - n0, 0);
                chk("zero_fs", int'(bus.frames_sent), 0);

                go(PAT_1001, 3, 0);
                got = 0;
                for (int i = 0; i < 20; i++) begin
                    if (bits_tot - n0 == 6) begin
                        got = 1;
                        break;
                    end
                    cyc();
                end
                chk("abort_reach", got, 1);
                bus.abort = 1'b1;
                cyc();
                bus.abort = 1'b0;
                chk("abort_valid", int'(bus.dout_valid), 0);
                chk("abort_busy", int'(bus.busy), 0);
                chk("abort_fs", int'(bus.frames_sent), 1);
                repeat (4) cyc();
                chk("abort_nodone", done_tot - d0, 0);
                go(PAT_1011, 1, 0);
                wait_done(30);
                chk("post_abort_bits", int'(stream[3:0]), int'(PAT_1011));
                chk("post_abort_fs", int'(bus.frames_sent), 1);

                go(PAT_1011, 3, 1);
                repeat (3) cyc();
                @(posedge clk);
                #3 reset = 1'b1;
                #1;
                chk("arst_dout", int'(bus.dout), 0);
                chk("arst_valid", int'(bus.dout_valid), 0);
                chk("arst_busy", int'(bus.busy), 0);
                chk("arst_fs", int'(bus.frames_sent), 0);
                cyc();
                reset = 1'b0;
                repeat (3) cyc();
                chk("arst_nodone", done_tot - d0, 0);
                go(PAT_1001, 2, 1);
                wait_done(30);
                chk("post_rst_busy", busy_tot - b0, 10);
                chk("post_rst_fs", int'(bus.frames_sent), 2);

                for (int i = 0; i < 3000; i++) begin
                    cyc();
                    bus.start      = ($urandom_range(0, 3) == 0);
                    bus.abort      = ($urandom_range(0, 39) == 0);
                    bus.pattern    = PW'($urandom);
                    bus.gap_len    = CW'($urandom_range(0, 3));
                    if ($urandom_range(0, 50) == 0)
                        bus.repeat_cnt = '1;
                    else
                        bus.repeat_cnt = CW'($urandom_range(0, 4));
                end
                bus.start = 1'b0;
                bus.abort = 1'b0;
                repeat (4) cyc();
                finished = 1'b1;
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Moore-style serial pattern transmitter: the generating end of the serial sequence-detector link.
- Loads a PAT_W-bit pattern and serializes it MSB-first, one bit per clock, for a programmable number of frames with optional idle gaps between them.
- Drives the din input of the sequence-detector blocks; provides pre-built overlapping and non-overlapping streams (e.g. 1001 / 1011) for detector benches and on-chip self-test.

Parameters:
- PAT_W, 4, pattern width in bits (2..16).
- CNT_W, 4, width of repeat count and gap length fields.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a transfer; sampled in IDLE only.
- abort  input  1  synchronous cancel of an in-progress transfer.
- pattern  input  PAT_W  bit pattern to send, MSB transmitted first.
- repeat_cnt  input  CNT_W  number of frames to send; 0 = none.
- gap_len  input  CNT_W  idle cycles inserted between frames; 0 = back-to-back.
- dout  output  1  serial data bit.
- dout_valid  output  1  high while dout carries a pattern bit.
- busy  output  1  high from start acceptance until return to IDLE.
- done  output  1  one-cycle pulse on normal completion.
- frames_sent  output  CNT_W  frames fully transmitted in current/last transfer.

Behaviour:
- Reset (async, active-high): state IDLE; dout, dout_valid, busy, done = 0; frames_sent = 0; internal shift register and counters cleared. Reset may assert mid-frame; the partial frame is discarded and no done pulse is issued.
- All outputs are registered (Moore); none depend combinationally on inputs.
- FSM states:
  - IDLE: outputs low. start=1 captures pattern, repeat_cnt, gap_len; clears frames_sent; sets busy. If repeat_cnt != 0, go to SEND; if repeat_cnt == 0, go to DONE.
  - SEND: dout = current MSB of the shift register, dout_valid = 1. Shift left each cycle. A bit counter runs PAT_W-1 down to 0.
  - GAP: dout = 0, dout_valid = 0; stays gap_len cycles.
  - DONE: done = 1 and busy = 1 for exactly one cycle, then IDLE.
- Latency: with start sampled at edge E0, the first pattern bit appears on dout after E1 and is held for one cycle. Frame k occupies PAT_W consecutive cycles.
- End of frame (last bit being driven): frames_sent increments at the following edge.
  - If frames remain and gap_len > 0: go to GAP.
  - If frames remain and gap_len = 0: reload the shift register from the captured pattern and stay in SEND. There is no bubble, so the stream is continuous.
  - If no frames remain: go to DONE.
- GAP exit: reload the pattern and go to SEND.
- Captured values are frozen during busy. Changes on pattern, repeat_cnt or gap_len take effect only at the next accepted start.
- start while busy: ignored, no queuing.
- start in the DONE cycle: ignored. It is accepted only from IDLE, one cycle later.
- abort (any state except IDLE): next edge goes to IDLE, all outputs 0, no done pulse, frames_sent holds its value.
- abort in IDLE: no effect.
- Simultaneous abort and start in IDLE: start wins.
- frames_sent saturates at 2^CNT_W-1 and cannot exceed repeat_cnt.
- Total busy duration for N frames, gap G:
  - N≥1: N*PAT_W + (N-1)*G + 1 (DONE) cycles.
  - N=0: 1 cycle.

Decomposition:
- Shared package seq_pkg:
  - state enum {IDLE, SEND, GAP, DONE} and its 2-bit encoding.
  - default widths PAT_W_DEF=4, CNT_W_DEF=4.
  - canonical pattern constants PAT_1001=4'b1001 and PAT_1011=4'b1011, shared with the detectors.
- One sub-module, piso_shift: a PAT_W-bit parallel-load, shift-left register with load and shift enables, async reset, and serial MSB output. The FSM, bit counter, frame counter and gap counter remain in seq_pattern_tx.

Test Plan:
- Single frame: pattern=1001, repeat_cnt=1, gap_len=0, start pulse at E0
  -> dout_valid high E1..E4 with dout=1,0,0,1; done pulse in cycle after E5; frames_sent=1; busy 5 cycles.
- Back-to-back: pattern=1001, repeat_cnt=2, gap_len=0
  -> dout=10011001 continuous with no dout_valid gap; a 1001 overlapping detector fed from dout flags 2 matches; done after 9 busy cycles.
- Gap insertion: pattern=1011, repeat_cnt=3, gap_len=2
  -> 1011, 2 cycles valid=0/dout=0, 1011, 2 idle, 1011; busy = 12+4+1 = 17 cycles; frames_sent=3.
- Zero count: repeat_cnt=0, start
  -> dout_valid never rises; busy and done high for exactly 1 cycle; frames_sent=0.
- Abort mid-frame: repeat_cnt=3, abort asserted during 2nd bit of frame 2
  -> IDLE next edge, outputs 0, no done pulse, frames_sent=1; a new start is then accepted normally.
- Async reset mid-transfer: reset pulse between edges during SEND
  -> dout, dout_valid, busy drop immediately without waiting for clk; frames_sent=0. start during busy in any other run is ignored, with pattern change mid-transfer not affecting output bits.
